// File: rtl/issue_if.sv
// ID1 -> issue queue -> ID2 handshake bundle: two enqueue slots in, two issue slots out.
interface issue_if #(
  parameter int DATA_W = 128
);
  logic              in0_valid;
  logic [DATA_W-1:0] in0_data;
  logic [17:0]       in0_meta;
  logic              in1_valid;
  logic [DATA_W-1:0] in1_data;
  logic [17:0]       in1_meta;
  logic              in_ready;
  logic              issue0_valid;
  logic [DATA_W-1:0] issue0_data;
  logic [17:0]       issue0_meta;
  logic              issue1_valid;
  logic [DATA_W-1:0] issue1_data;
  logic [17:0]       issue1_meta;

  modport master (
    output in0_valid, in0_data, in0_meta, in1_valid, in1_data, in1_meta,
    input  in_ready, issue0_valid, issue0_data, issue0_meta,
    input  issue1_valid, issue1_data, issue1_meta
  );

  modport slave (
    input  in0_valid, in0_data, in0_meta, in1_valid, in1_data, in1_meta,
    output in_ready, issue0_valid, issue0_data, issue0_meta,
    output issue1_valid, issue1_data, issue1_meta
  );
endinterface

// File: rtl/issue_ctrl.sv
// Dual-issue instruction queue: circular buffer fed two-wide from ID1, issuing
// zero, one or two head entries per cycle to the ID2 slot registers.
module issue_ctrl #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 128
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   exception_flush,
  input  logic                   id2_stall,
  issue_if.slave                 bus,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [17:0]       r_meta [DEPTH];
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic [AW-1:0] w_head1;
  logic [AW-1:0] w_tail1;
  logic [17:0]   w_h0;
  logic [17:0]   w_h1;
  logic          w_raw;
  logic          w_waw;
  logic          w_issue0;
  logic          w_issue1;
  logic          w_in_ready;
  logic          w_enq;
  logic          w_enq2;
  logic [CW-1:0] w_enq_n;
  logic [CW-1:0] w_deq_n;

  assign w_head1 = r_head + AW'(1);
  assign w_tail1 = r_tail + AW'(1);
  assign w_h0    = r_meta[r_head];
  assign w_h1    = r_meta[w_head1];

  // meta layout: [17] branch, [16] load/store, [15] wr_en, [14:10] dst, [9:5] rs, [4:0] rt
  always_comb begin
    w_raw      = w_h0[15] && (w_h0[14:10] != 5'd0) &&
                 ((w_h0[14:10] == w_h1[9:5]) || (w_h0[14:10] == w_h1[4:0]));
    w_waw      = w_h0[15] && w_h1[15] && (w_h0[14:10] == w_h1[14:10]) &&
                 (w_h0[14:10] != 5'd0);
    w_issue0   = (r_count != '0) && !(w_h0[17] && (r_count < CW'(2)));
    w_issue1   = w_issue0 && (r_count >= CW'(2)) && !w_raw && !w_waw &&
                 !(w_h0[16] && w_h1[16]) && !w_h1[17];
    w_in_ready = rst_n && ((CW'(DEPTH) - r_count) >= CW'(2));
    w_enq      = w_in_ready && bus.in0_valid;
    w_enq2     = w_enq && bus.in1_valid;
    w_enq_n    = CW'(w_enq) + CW'(w_enq2);
    w_deq_n    = id2_stall ? '0 : (CW'(w_issue0) + CW'(w_issue1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush || exception_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_deq_n);
      r_tail  <= r_tail + AW'(w_enq_n);
      r_count <= r_count + w_enq_n - w_deq_n;
    end
  end

  // Payload storage needs no reset; entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_data[r_tail] <= bus.in0_data;
      r_meta[r_tail] <= bus.in0_meta;
    end
    if (w_enq2) begin
      r_data[w_tail1] <= bus.in1_data;
      r_meta[w_tail1] <= bus.in1_meta;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.issue0_valid = w_issue0;
  assign bus.issue0_data  = r_data[r_head];
  assign bus.issue0_meta  = w_h0;
  assign bus.issue1_valid = w_issue1;
  assign bus.issue1_data  = r_data[w_head1];
  assign bus.issue1_meta  = w_h1;
  assign count            = r_count;
endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed vector table, async reset sequence and a
// randomized run, all checked against a queue-based model of the issue rules.
module tb_issue_ctrl;
  localparam int DEPTH = 8;
  localparam int DW    = 128;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       exception_flush;
  logic       id2_stall;
  logic [3:0] count;

  always #5 clk = ~clk;

  issue_if #(.DATA_W(DW)) bus ();

  issue_ctrl #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .exception_flush (exception_flush),
    .id2_stall       (id2_stall),
    .bus             (bus),
    .count           (count)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [17:0]   m;
  } ent_t;

  typedef struct {
    bit          f;
    bit          xf;
    bit          st;
    bit          v0;
    bit          v1;
    logic [17:0] m0;
    logic [17:0] m1;
    int          ecnt;
    bit          erdy;
    bit          ev0;
    bit          ev1;
  } vec_t;

  ent_t q[$];
  vec_t tbl[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic [17:0] mk(bit br, bit ls, bit we, int dst, int rs, int rt);
    return {br, ls, we, 5'(dst), 5'(rs), 5'(rt)};
  endfunction

  // A later instruction may pair with an earlier one only if it neither reads
  // nor rewrites the earlier one's nonzero destination, they don't both use
  // memory, and the later one is not a branch.
  function automatic bit pair_blocked(logic [17:0] a, logic [17:0] b);
    bit a_writes = a[15] && (a[14:10] != 5'd0);
    bit reads    = a_writes && ((a[14:10] == b[9:5]) || (a[14:10] == b[4:0]));
    bit rewrites = a_writes && b[15] && (a[14:10] == b[14:10]);
    return reads || rewrites || (a[16] && b[16]) || b[17];
  endfunction

  function automatic bit exp_v0();
    if (q.size() == 0) return 1'b0;
    if (q[0].m[17] && q.size() < 2) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_v1();
    if (!exp_v0() || q.size() < 2) return 1'b0;
    return !pair_blocked(q[0].m, q[1].m);
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic drive(bit f, bit xf, bit st, bit v0, bit v1, logic [17:0] m0, logic [17:0] m1);
    flush           = f;
    exception_flush = xf;
    id2_stall       = st;
    bus.in0_valid   = v0;
    bus.in1_valid   = v1;
    bus.in0_meta    = m0;
    bus.in1_meta    = m1;
    bus.in0_data    = {$urandom, $urandom, $urandom, $urandom};
    bus.in1_data    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic check_model();
    int sz = q.size();
    bit e0 = exp_v0();
    bit e1 = exp_v1();
    chk("count", 128'(count), 128'(sz));
    chk("in_ready", 128'(bus.in_ready), 128'(DEPTH - sz >= 2));
    chk("issue0_valid", 128'(bus.issue0_valid), 128'(e0));
    chk("issue1_valid", 128'(bus.issue1_valid), 128'(e1));
    if (e0) begin
      chk("issue0_data", bus.issue0_data, q[0].d);
      chk("issue0_meta", 128'(bus.issue0_meta), 128'(q[0].m));
    end
    if (e1) begin
      chk("issue1_data", bus.issue1_data, q[1].d);
      chk("issue1_meta", 128'(bus.issue1_meta), 128'(q[1].m));
    end
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic adv();
    bit   rdy  = (DEPTH - q.size() >= 2);
    int   npop = id2_stall ? 0 : (int'(exp_v0()) + int'(exp_v1()));
    bit   clr  = flush || exception_flush;
    bit   e0   = rdy && bus.in0_valid;
    bit   e1   = e0 && bus.in1_valid;
    ent_t a    = '{d: bus.in0_data, m: bus.in0_meta};
    ent_t b    = '{d: bus.in1_data, m: bus.in1_meta};
    @(posedge clk);
    #1;
    if (clr) begin
      q.delete();
    end else begin
      repeat (npop) void'(q.pop_front());
      if (e0) q.push_back(a);
      if (e1) q.push_back(b);
    end
  endtask

  function automatic void row(bit f, bit xf, bit st, bit v0, bit v1, logic [17:0] m0,
                              logic [17:0] m1, int ecnt, bit erdy, bit ev0, bit ev1);
    vec_t r;
    r.f = f; r.xf = xf; r.st = st; r.v0 = v0; r.v1 = v1; r.m0 = m0; r.m1 = m1;
    r.ecnt = ecnt; r.erdy = erdy; r.ev0 = ev0; r.ev1 = ev1;
    tbl.push_back(r);
  endfunction

  initial begin
    logic [17:0] alu_a, alu_b, raw_c, raw_d, br, ds, ls0, ls1, waw0, waw1, z0, z1, nul;
    alu_a = mk(0, 0, 1, 1, 3, 4);
    alu_b = mk(0, 0, 1, 2, 3, 4);
    raw_c = mk(0, 0, 1, 5, 1, 2);
    raw_d = mk(0, 0, 1, 6, 5, 0);
    br    = mk(1, 0, 0, 0, 1, 2);
    ds    = mk(0, 0, 1, 7, 3, 4);
    ls0   = mk(0, 1, 1, 8, 1, 2);
    ls1   = mk(0, 1, 0, 0, 3, 4);
    waw0  = mk(0, 0, 1, 9, 1, 2);
    waw1  = mk(0, 0, 1, 9, 3, 4);
    z0    = mk(0, 0, 1, 0, 1, 2);
    z1    = mk(0, 0, 1, 10, 0, 0);
    nul   = '0;

    //   f  xf st v0 v1 m0     m1     cnt rdy iv0 iv1   (expected before the edge)
    row(0, 0, 0, 1, 1, alu_a, alu_b, 0, 1, 0, 0);
    row(0, 0, 0, 0, 0, nul,   nul,   2, 1, 1, 1);
    row(0, 0, 0, 0, 1, alu_a, alu_b, 0, 1, 0, 0);
    row(0, 0, 0, 1, 1, raw_c, raw_d, 0, 1, 0, 0);
    row(0, 0, 0, 0, 0, nul,   nul,   2, 1, 1, 0);
    row(0, 0, 0, 0, 0, nul,   nul,   1, 1, 1, 0);
    row(0, 0, 0, 0, 0, nul,   nul,   0, 1, 0, 0);
    row(0, 0, 0, 1, 0, br,    nul,   0, 1, 0, 0);
    row(0, 0, 0, 1, 0, ds,    nul,   1, 1, 0, 0);
    row(0, 0, 0, 0, 0, nul,   nul,   2, 1, 1, 1);
    row(0, 0, 0, 0, 0, nul,   nul,   0, 1, 0, 0);
    row(0, 0, 1, 1, 1, alu_a, alu_b, 0, 1, 0, 0);
    row(0, 0, 1, 1, 1, alu_a, alu_b, 2, 1, 1, 1);
    row(0, 0, 1, 1, 1, alu_a, alu_b, 4, 1, 1, 1);
    row(0, 0, 1, 1, 0, alu_a, nul,   6, 1, 1, 1);
    row(0, 0, 1, 1, 1, alu_a, alu_b, 7, 0, 1, 1);
    row(0, 0, 1, 0, 0, nul,   nul,   7, 0, 1, 1);
    row(0, 0, 1, 0, 0, nul,   nul,   7, 0, 1, 1);
    row(0, 0, 0, 0, 0, nul,   nul,   7, 0, 1, 1);
    row(1, 0, 0, 1, 1, alu_a, alu_b, 5, 1, 1, 1);
    row(0, 0, 0, 1, 1, alu_a, alu_b, 0, 1, 0, 0);
    row(0, 0, 1, 1, 1, alu_a, alu_b, 2, 1, 1, 1);
    row(0, 0, 1, 1, 0, alu_a, nul,   4, 1, 1, 1);
    row(0, 1, 1, 1, 1, alu_a, alu_b, 5, 1, 1, 1);
    row(0, 0, 0, 1, 1, ls0,   ls1,   0, 1, 0, 0);
    row(0, 0, 0, 0, 0, nul,   nul,   2, 1, 1, 0);
    row(0, 0, 0, 0, 0, nul,   nul,   1, 1, 1, 0);
    row(0, 0, 0, 1, 1, waw0,  waw1,  0, 1, 0, 0);
    row(0, 0, 0, 0, 0, nul,   nul,   2, 1, 1, 0);
    row(0, 0, 0, 0, 0, nul,   nul,   1, 1, 1, 0);
    row(0, 0, 0, 1, 1, z0,    z1,    0, 1, 0, 0);
    row(0, 0, 0, 0, 0, nul,   nul,   2, 1, 1, 1);
    row(0, 0, 0, 1, 1, alu_a, br,    0, 1, 0, 0);
    row(0, 0, 0, 0, 0, nul,   nul,   2, 1, 1, 0);
    row(0, 0, 0, 1, 0, ds,    nul,   1, 1, 0, 0);
    row(0, 0, 0, 0, 0, nul,   nul,   2, 1, 1, 1);
    row(0, 0, 0, 0, 0, nul,   nul,   0, 1, 0, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, nul, nul);
    #12;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
    chk("rst_issue0_valid", 128'(bus.issue0_valid), 128'(0));
    chk("rst_issue1_valid", 128'(bus.issue1_valid), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i].f, tbl[i].xf, tbl[i].st, tbl[i].v0, tbl[i].v1, tbl[i].m0, tbl[i].m1);
      @(negedge clk);
      chk($sformatf("vec%0d_count", i), 128'(count), 128'(tbl[i].ecnt));
      chk($sformatf("vec%0d_in_ready", i), 128'(bus.in_ready), 128'(tbl[i].erdy));
      chk($sformatf("vec%0d_issue0_valid", i), 128'(bus.issue0_valid), 128'(tbl[i].ev0));
      chk($sformatf("vec%0d_issue1_valid", i), 128'(bus.issue1_valid), 128'(tbl[i].ev1));
      check_model();
      adv();
    end

    // Asynchronous reset in the middle of a cycle with four entries queued.
    drive(0, 0, 1, 1, 1, alu_a, alu_b);
    @(negedge clk); check_model(); adv();
    drive(0, 0, 1, 1, 1, alu_a, alu_b);
    @(negedge clk); check_model(); adv();
    drive(0, 0, 1, 0, 0, nul, nul);
    @(negedge clk);
    check_model();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 128'(count), 128'(0));
    chk("async_rst_in_ready", 128'(bus.in_ready), 128'(0));
    chk("async_rst_issue0_valid", 128'(bus.issue0_valid), 128'(0));
    chk("async_rst_issue1_valid", 128'(bus.issue1_valid), 128'(0));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 1) == 1,
            mk($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)),
            mk($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)));
      @(negedge clk);
      check_model();
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
